// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the multiply/divide unit: MDOp encodings and FSM states.
// Also used by the decoder and the hazard unit.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_RSV6  = 3'd6,
    MD_RSV7  = 3'd7
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // MULT/MULTU/DIV/DIVU are the multi-cycle ops; they occupy encodings 0..3.
  function automatic logic is_long_op(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// EX-stage multi-cycle multiply/divide unit owning HI/LO; MDBusy stalls the
// front of the pipeline from the accept cycle until the result commits.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        MDBusy
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  md_state_e          state_q;
  logic [3:0]         count_q;
  logic [63:0]        res_q, res_d;
  logic               divz_q, divz_d;
  logic [31:0]        hi_q, lo_q;
  md_op_e             op_in;
  logic               accept;
  logic signed [31:0] sa, sb;

  assign op_in  = md_op_e'(MDOp);
  assign sa     = $signed(A);
  assign sb     = $signed(B);
  assign accept = Start & (state_q == MD_IDLE) & is_long_op(MDOp);
  assign MDBusy = accept | (state_q == MD_RUN);
  assign HI     = hi_q;
  assign LO     = lo_q;

  // Result is computed from the live operands and captured at accept; only
  // the commit edge is architecturally visible.
  always_comb begin
    res_d  = '0;
    divz_d = 1'b0;
    case (op_in)
      MD_MULT:  res_d = {{32{A[31]}}, A} * {{32{B[31]}}, B};
      MD_MULTU: res_d = {32'b0, A} * {32'b0, B};
      MD_DIV: begin
        if (B == '0) begin
          divz_d = 1'b1;
        end else if (A == 32'h8000_0000 && B == '1) begin
          res_d = {32'h0, 32'h8000_0000};
        end else begin
          res_d = {32'(sa % sb), 32'(sa / sb)};
        end
      end
      MD_DIVU: begin
        if (B == '0) begin
          divz_d = 1'b1;
        end else begin
          res_d = {A % B, A / B};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= MD_IDLE;
      count_q <= '0;
      res_q   <= '0;
      divz_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (Start) begin
            if (is_long_op(MDOp)) begin
              state_q <= MD_RUN;
              count_q <= MDOp[1] ? DIV_CNT : MULT_CNT;
              res_q   <= res_d;
              divz_q  <= divz_d;
            end else if (op_in == MD_MTHI) begin
              hi_q <= A;
            end else if (op_in == MD_MTLO) begin
              lo_q <= A;
            end
          end
        end
        MD_RUN: begin
          count_q <= count_q - 4'd1;
          if (count_q == 4'd1) begin
            state_q <= MD_IDLE;
            if (!divz_q) begin
              hi_q <= res_q[63:32];
              lo_q <= res_q[31:0];
            end
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized bench for muldiv_unit against a longint-based
// arithmetic model of HI/LO and the 1+N busy window.
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic [31:0] HI, LO;
  logic        MDBusy;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .CLK(CLK), .RSTn(RSTn), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .HI(HI), .LO(LO), .MDBusy(MDBusy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = longint'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = 32'(q); m_hi = 32'(r); end
      3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int busy;
    int exp_busy;
    logic [31:0] old_hi, old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    @(negedge CLK);
    Start = 1'b1; MDOp = op; A = a; B = b;
    #1;
    check({tag, " busy_accept"}, {31'b0, MDBusy}, (op <= 3'd3) ? 32'd1 : 32'd0);
    busy = MDBusy ? 1 : 0;
    @(posedge CLK);
    #1 Start = 1'b0;
    A = $urandom; B = $urandom;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (!MDBusy) break;
      busy++;
      check({tag, " hold_hi"}, HI, old_hi);
      check({tag, " hold_lo"}, LO, old_lo);
    end
    exp_busy = (op <= 3'd1) ? 6 : (op <= 3'd3) ? 11 : 0;
    check({tag, " busy_cycles"}, 32'(busy), 32'(exp_busy));
    model(op, a, b);
    check({tag, " hi"}, HI, m_hi);
    check({tag, " lo"}, LO, m_lo);
  endtask

  initial begin
    int busy;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [31:0] old_hi, old_lo;

    RSTn = 1'b0; Start = 1'b0; MDOp = '0; A = '0; B = '0;
    m_hi = '0; m_lo = '0;
    #1;
    check("reset hi", HI, 32'h0);
    check("reset lo", LO, 32'h0);
    check("reset busy", {31'b0, MDBusy}, 32'd0);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;

    run_op("mult_neg",  3'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    run_op("multu",     3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    run_op("div_neg",   3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op("divu",      3'd3, 32'd7, 32'd2);
    run_op("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("mthi",      3'd4, 32'h11, 32'h0);
    run_op("mtlo",      3'd5, 32'h22, 32'h0);
    run_op("divu_zero", 3'd3, 32'h1234_5678, 32'h0);
    run_op("div_zero",  3'd2, 32'h8765_4321, 32'h0);
    run_op("rsv6",      3'd6, 32'hDEAD_BEEF, 32'h1);
    run_op("rsv7",      3'd7, 32'hCAFE_F00D, 32'h1);

    for (int n = 0; n < 30; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 9));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
      run_op("random", rop, ra, rb);
    end

    // Overlapping starts during a MULT run must be ignored.
    old_hi = m_hi; old_lo = m_lo;
    @(negedge CLK);
    Start = 1'b1; MDOp = 3'd0; A = 32'h0001_2345; B = 32'hFFFF_FF00;
    @(posedge CLK);
    #1 MDOp = 3'd5; A = 32'h55; B = 32'h0;
    busy = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (!MDBusy) break;
      busy++;
      check("overlap hold_hi", HI, old_hi);
      check("overlap hold_lo", LO, old_lo);
      if (busy == 2) begin MDOp = 3'd2; A = 32'd100; B = 32'd3; end
      if (busy == 3) Start = 1'b0;
    end
    Start = 1'b0;
    check("overlap busy_cycles", 32'(busy), 32'd6);
    model(3'd0, 32'h0001_2345, 32'hFFFF_FF00);
    check("overlap hi", HI, m_hi);
    check("overlap lo", LO, m_lo);

    // Async reset part-way through a DIV.
    run_op("pre_rst_mthi", 3'd4, 32'hAAAA_5555, 32'h0);
    @(negedge CLK);
    Start = 1'b1; MDOp = 3'd2; A = 32'd1000; B = 32'd7;
    @(posedge CLK);
    #1 Start = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RSTn = 1'b0;
    #1;
    check("midrst busy", {31'b0, MDBusy}, 32'd0);
    check("midrst hi", HI, 32'h0);
    check("midrst lo", LO, 32'h0);
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    run_op("post_rst_multu", 3'd1, 32'd3, 32'd4);
    check("post_rst lo12", LO, 32'd12);
    check("post_rst hi0", HI, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
